// File: rtl/mem_pkg.sv
// Shared constants and bank-select helper for the four-bank interleaved memory.
package mem_pkg;

    localparam int BANK_SEL_LSB = 32'sd1;
    localparam int NUM_BANKS    = 32'sd4;
    localparam int BUSY_CYC     = 32'sd4;
    localparam int RD_LAT       = 32'sd2;

    function automatic logic [1:0] bank_of(input logic [31:0] addr);
        return addr[BANK_SEL_LSB +: 2];
    endfunction

endpackage

// File: rtl/mem_bank.sv
// One memory bank: a word array with a single port plus its occupancy counter.
module mem_bank
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic [ADDR_W-4:0] i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);

    localparam int DEPTH = 32'sd1 << (ADDR_W - 3);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_cnt;
    logic              r_busy;

    // Array write port; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (i_acc && i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Occupancy counter; busy flag is kept as its own register, equal to cnt != 0
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 2'd0;
            r_busy <= 1'b0;
        end else if (i_acc) begin
            r_cnt  <= 2'(BUSY_CYC - 1);
            r_busy <= 1'b1;
        end else if (r_cnt != 2'd0) begin
            r_cnt  <= r_cnt - 2'd1;
            r_busy <= (r_cnt != 2'd1);
        end else begin
            r_cnt  <= 2'd0;
            r_busy <= 1'b0;
        end
    end

    assign o_rdata = r_mem[i_widx];
    assign o_busy  = r_busy;

endmodule

// File: rtl/banked_mem_resp.sv
// Four-bank word-interleaved memory responder: request decode, bank arrays,
// and a fixed-latency read return path.
module banked_mem_resp
    import mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W-1:0]    i_data_in,
    input  logic                 i_wr,
    input  logic                 i_rd,
    output logic [DATA_W-1:0]    o_data_out,
    output logic                 o_stall,
    output logic [NUM_BANKS-1:0] o_busy,
    output logic                 o_err
);

    logic                 w_req;
    logic                 w_err;
    logic                 w_stall;
    logic                 w_acc;
    logic [1:0]           w_bank;
    logic [ADDR_W-4:0]    w_widx;
    logic [NUM_BANKS-1:0] w_bank_acc;
    logic [NUM_BANKS-1:0] w_busy;
    logic [DATA_W-1:0]    w_rdata [NUM_BANKS];
    logic [DATA_W-1:0]    w_rsel;

    logic                 r_pipe_v [RD_LAT];
    logic [DATA_W-1:0]    r_pipe_d [RD_LAT];
    logic [DATA_W-1:0]    r_data_out;

    assign w_widx = i_addr[ADDR_W-1:3];

    // Request decode: illegal requests win over stall and never reach a bank
    always_comb begin
        w_req   = i_rd | i_wr;
        w_bank  = bank_of(32'(i_addr));
        w_err   = (i_rd & i_wr) | (w_req & i_addr[0]);
        w_stall = w_req & ~w_err & w_busy[w_bank];
        w_acc   = w_req & ~w_err & ~w_stall;
        w_rsel  = w_rdata[w_bank];
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_acc[b] = w_acc & (w_bank == 2'(b));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_acc   (w_bank_acc[g]),
            .i_we    (i_wr),
            .i_widx  (w_widx),
            .i_wdata (i_data_in),
            .o_rdata (w_rdata[g]),
            .o_busy  (w_busy[g])
        );
    end

    // Read return: snapshot at accept, shift every edge, pulse data_out for one cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_v[i] <= 1'b0;
                r_pipe_d[i] <= {DATA_W{1'b0}};
            end
            r_data_out <= {DATA_W{1'b0}};
        end else begin
            r_pipe_v[0] <= w_acc & i_rd;
            r_pipe_d[0] <= w_rsel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_d[i] <= r_pipe_d[i-1];
            end
            r_data_out <= r_pipe_v[RD_LAT-1] ? r_pipe_d[RD_LAT-1] : {DATA_W{1'b0}};
        end
    end

    assign o_data_out = r_data_out;
    assign o_stall    = w_stall;
    assign o_err      = w_err;
    assign o_busy     = w_busy;

endmodule
